// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 interrupt entry path: mcause codes,
// the interrupt controller state encoding and the cause priority helper.
package jedro_1_defines;

    localparam logic [4:0] CSR_MCAUSE_M_SW_IRQ    = 5'd3;
    localparam logic [4:0] CSR_MCAUSE_M_TIMER_IRQ = 5'd7;
    localparam logic [4:0] CSR_MCAUSE_M_EXT_IRQ   = 5'd11;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_DRAIN = 2'd1,
        IRQ_TAKE  = 2'd2,
        IRQ_HOLD  = 2'd3
    } irq_ctrl_state_e;

    // pend is {ext, sw, timer}; external beats software beats timer
    function automatic logic [4:0] irq_code(input logic [2:0] pend);
        if (pend[2])      return CSR_MCAUSE_M_EXT_IRQ;
        else if (pend[1]) return CSR_MCAUSE_M_SW_IRQ;
        else              return CSR_MCAUSE_M_TIMER_IRQ;
    endfunction

endpackage

// File: rtl/jedro_1_sync2.sv
// Two-flop synchronizer for level signals crossing into clk_i; flops clear
// to 0 on the asynchronous reset.
module jedro_1_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/jedro_1_irq_ctrl.sv
// Machine-mode interrupt entry scheduler: qualify, drain, take, hold.
// Define JEDRO_1_IRQ_SYNC_EN to pass the irq lines through 2-flop synchronizers.
module jedro_1_irq_ctrl
    import jedro_1_defines::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sw_irq_i,
    input  logic                  timer_irq_i,
    input  logic                  ext_irq_i,
    input  logic                  mstatus_mie_i,
    input  logic                  mie_msie_i,
    input  logic                  mie_mtie_i,
    input  logic                  mie_meie_i,
    input  logic                  pipe_empty_i,
    input  logic [DATA_WIDTH-1:0] next_pc_i,
    input  logic                  exception_i,
    input  logic                  mret_i,
    output logic                  stall_o,
    output logic                  irq_take_o,
    output logic [DATA_WIDTH-1:0] irq_cause_o,
    output logic [DATA_WIDTH-1:0] irq_epc_o,
    output logic                  drain_timeout_o
);

    localparam int CNT_W = $clog2(DRAIN_TIMEOUT);

    logic [2:0] irq_lines;
    logic [2:0] irq_lines_s;
    logic [2:0] pend;

    assign irq_lines = {ext_irq_i, sw_irq_i, timer_irq_i};

`ifdef JEDRO_1_IRQ_SYNC_EN
    jedro_1_sync2 #(
        .WIDTH(3)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (irq_lines),
        .q_o  (irq_lines_s)
    );
`else
    assign irq_lines_s = irq_lines;
`endif

    assign pend = irq_lines_s & {mie_meie_i, mie_msie_i, mie_mtie_i} & {3{mstatus_mie_i}};

    irq_ctrl_state_e       state_d, state_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic                  stall_d, stall_q;
    logic                  take_d, take_q;
    logic [DATA_WIDTH-1:0] cause_d, cause_q;
    logic [DATA_WIDTH-1:0] epc_d, epc_q;
    logic                  tmo_d, tmo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cause_d = cause_q;
        epc_d   = epc_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (|pend && !exception_i && !mret_i) state_d = IRQ_DRAIN;
            end
            IRQ_DRAIN: begin
                if (exception_i || mret_i || pend == 3'b000) begin
                    state_d = IRQ_IDLE;
                end else if (pipe_empty_i) begin
                    state_d                 = IRQ_TAKE;
                    cause_d                 = '0;
                    cause_d[DATA_WIDTH-1]   = 1'b1;
                    cause_d[4:0]            = irq_code(pend);
                    epc_d                   = next_pc_i;
                end else if (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d = IRQ_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IRQ_TAKE: state_d = IRQ_HOLD;
            // stay until the CSR write clearing MIE is visible, so we cannot re-enter
            IRQ_HOLD: begin
                if (!mstatus_mie_i) state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
        stall_d = (state_d == IRQ_DRAIN) || (state_d == IRQ_TAKE);
        take_d  = (state_d == IRQ_TAKE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IRQ_IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            take_q  <= 1'b0;
            cause_q <= '0;
            epc_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            take_q  <= take_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tmo_q   <= tmo_d;
        end
    end

    assign stall_o         = stall_q;
    assign irq_take_o      = take_q;
    assign irq_cause_o     = cause_q;
    assign irq_epc_o       = epc_q;
    assign drain_timeout_o = tmo_q;

endmodule

// File: tb/tb_jedro_1_irq_ctrl.sv
// Directed bench for jedro_1_irq_ctrl: take pulses are checked by a scoreboard
// monitor against expected cause/epc/cycle pushed by the stimulus thread.
module tb_jedro_1_irq_ctrl;

    localparam int DW = 32;
`ifdef JEDRO_1_IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw_irq = 0, timer_irq = 0, ext_irq = 0;
    logic          mstatus_mie = 0, msie = 0, mtie = 0, meie = 0;
    logic          pipe_empty = 0, exception = 0, mret = 0;
    logic [DW-1:0] next_pc = '0;
    logic          stall, take, dto;
    logic [DW-1:0] cause, epc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] cause;
        logic [DW-1:0] epc;
        int            at;
    } exp_t;
    exp_t sb[$];

    jedro_1_irq_ctrl #(
        .DATA_WIDTH   (DW),
        .DRAIN_TIMEOUT(16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sw_irq_i       (sw_irq),
        .timer_irq_i    (timer_irq),
        .ext_irq_i      (ext_irq),
        .mstatus_mie_i  (mstatus_mie),
        .mie_msie_i     (msie),
        .mie_mtie_i     (mtie),
        .mie_meie_i     (meie),
        .pipe_empty_i   (pipe_empty),
        .next_pc_i      (next_pc),
        .exception_i    (exception),
        .mret_i         (mret),
        .stall_o        (stall),
        .irq_take_o     (take),
        .irq_cause_o    (cause),
        .irq_epc_o      (epc),
        .drain_timeout_o(dto)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor: every take pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && take) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL take_unexpected: got cause=%h epc=%h at cyc %0d, required no take",
                         cause, epc, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cause !== e.cause || epc !== e.epc || cyc != e.at) begin
                    bad++;
                    $display("FAIL take_match: got cause=%h epc=%h cyc=%0d, required cause=%h epc=%h cyc=%0d",
                             cause, epc, cyc, e.cause, e.epc, e.at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    typedef struct {
        logic          e, s, t;
        logic [DW-1:0] pc;
        logic [DW-1:0] exp_cause;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h8000_0007};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h8000_000B};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h8000_0003};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'h8000_000B};

        tick(2);
        chk("reset_stall", {31'd0, stall}, 0);
        chk("reset_take",  {31'd0, take}, 0);
        chk("reset_cause", cause, 0);
        chk("reset_epc",   epc, 0);
        chk("reset_dto",   {31'd0, dto}, 0);
        rst = 1'b0;
        tick(1);

        // priority/latency vectors: take at +LAT, then HOLD until MIE cleared
        foreach (vecs[i]) begin
            mstatus_mie = 1; msie = 1; mtie = 1; meie = 1; pipe_empty = 1;
            next_pc = vecs[i].pc;
            ext_irq = vecs[i].e; sw_irq = vecs[i].s; timer_irq = vecs[i].t;
            sb.push_back('{vecs[i].exp_cause, vecs[i].pc, cyc + LAT});
            tick(LAT - 1);
            chk("drain_stall", {31'd0, stall}, 1);
            tick(1);
            chk("take_pulse", {31'd0, take}, 1);
            chk("take_stall", {31'd0, stall}, 1);
            tick(1);
            chk("hold_stall", {31'd0, stall}, 0);
            tick(3);
            chk("hold_no_reentry", {31'd0, stall}, 0);
            chk("cause_held", cause, vecs[i].exp_cause);
            mstatus_mie = 0;
            tick(1);
            ext_irq = 0; sw_irq = 0; timer_irq = 0;
            tick(2);
        end

        // exception in the second DRAIN cycle aborts the entry
        mstatus_mie = 1; pipe_empty = 0; timer_irq = 1;
        tick(LAT - 1);
        chk("exc_drain1", {31'd0, stall}, 1);
        tick(1);
        exception = 1;
        tick(1);
        chk("exc_abort_stall", {31'd0, stall}, 0);
        exception = 0; timer_irq = 0;
        tick(3);
        chk("exc_no_timeout", {31'd0, dto}, 0);

        // mret in IDLE blocks entry that cycle
        timer_irq = 1; mret = 1;
        tick(LAT);
        chk("mret_blocks", {31'd0, stall}, 0);
        timer_irq = 0; mret = 0;
        tick(3);

        // pipeline never empties: 16 stall cycles, then sticky timeout
        timer_irq = 1;
        tick(LAT - 1);
        begin
            int scnt;
            scnt = 0;
            for (int k = 0; k < 16; k++) begin
                if (stall) scnt++;
                tick(1);
            end
            chk("timeout_stall_cycles", scnt, 16);
        end
        chk("timeout_idle", {31'd0, stall}, 0);
        chk("timeout_sticky", {31'd0, dto}, 1);
        timer_irq = 0;
        tick(4);
        chk("timeout_sticky_kept", {31'd0, dto}, 1);

        // disabled by MIE or per-line enable: never stalls
        mstatus_mie = 0; msie = 1; mtie = 1; meie = 1;
        ext_irq = 1; sw_irq = 1; timer_irq = 1; pipe_empty = 1;
        tick(6);
        chk("mie0_no_stall", {31'd0, stall}, 0);
        mstatus_mie = 1; msie = 0; mtie = 0; meie = 0;
        tick(6);
        chk("mask0_no_stall", {31'd0, stall}, 0);
        ext_irq = 0; sw_irq = 0; timer_irq = 0; msie = 1; mtie = 1; meie = 1;
        tick(2);

        // asynchronous reset mid-DRAIN
        pipe_empty = 0; timer_irq = 1;
        tick(LAT - 1);
        chk("rst_pre_stall", {31'd0, stall}, 1);
        #2 rst = 1;
        #1;
        chk("rst_async_stall", {31'd0, stall}, 0);
        chk("rst_async_dto",   {31'd0, dto}, 0);
        chk("rst_async_cause", cause, 0);
        chk("rst_async_epc",   epc, 0);
        tick(1);
        timer_irq = 0;
        rst = 0;
        tick(4);
        chk("post_rst_idle", {31'd0, stall}, 0);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL take_missing: got %0d outstanding, required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
